// File: rtl/pic_wb_pkg.sv
// Shared definitions for the PIC16C5x write-back path.
// Contents: request op encodings, STATUS flag bit positions, default widths,
// and a helper that decides whether a request writes the GPR file.
package pic_wb_pkg;

    // Default widths used by the write-back controller.
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_STATUS_W = 3;

    // STATUS flag positions.
    localparam int unsigned BIT_C  = 0;
    localparam int unsigned BIT_DC = 1;
    localparam int unsigned BIT_Z  = 2;

    // Request op encodings.
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLRF   = 3'd1;
    localparam logic [2:0] OP_CLRW   = 3'd2;
    localparam logic [2:0] OP_MOVWF  = 3'd3;
    localparam logic [2:0] OP_ALU_F  = 3'd4;
    localparam logic [2:0] OP_ALU_W  = 3'd5;
    localparam logic [2:0] OP_MOVF   = 3'd6;
    localparam logic [2:0] OP_FSR_LD = 3'd7;

    // True when the op (with its d bit) produces a GPR write.
    function automatic logic is_gpr_push(input logic [2:0] op, input logic dest);
        return (op == OP_CLRF) || (op == OP_MOVWF) ||
               (((op == OP_ALU_F) || (op == OP_MOVF)) && dest);
    endfunction

    // True when the op rewrites STATUS.
    function automatic logic is_status_upd(input logic [2:0] op);
        return (op == OP_CLRF) || (op == OP_CLRW) || (op == OP_ALU_F) ||
               (op == OP_ALU_W) || (op == OP_MOVF);
    endfunction

endpackage

// File: rtl/reg_write_queue_if.sv
// Request and GPR write-port bundle for reg_write_queue.
//   Request channel : req_valid/req_ready handshake plus op, d bit, address and
//                     the operand values (W, ALU result/flags, current STATUS).
//   Write channel   : wr_en/wr_ready handshake with wr_addr/wr_data.
// master : execute / register-file side (drives requests, absorbs writes).
// slave  : the write-back controller.
interface reg_write_queue_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned STATUS_W = 3
);
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic                req_dest;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   w_in;
    logic [DATA_W-1:0]   alu_result;
    logic [STATUS_W-1:0] alu_status;
    logic [DATA_W-1:0]   status_in;

    logic                wr_en;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    modport master (
        output req_valid, req_op, req_dest, req_addr, w_in, alu_result, alu_status, status_in,
        input  req_ready,
        input  wr_en, wr_addr, wr_data,
        output wr_ready
    );

    modport slave (
        input  req_valid, req_op, req_dest, req_addr, w_in, alu_result, alu_status, status_in,
        output req_ready,
        output wr_en, wr_addr, wr_data,
        input  wr_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of {addr, data} GPR writes with flush and an address search.
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_flush                    empty the queue next edge; a same-cycle push is dropped
//   i_push, i_push_addr/data   enqueue (ignored when full unless popping this cycle)
//   i_pop                      dequeue head (ignored when empty)
//   o_full                     DEPTH entries held
//   o_head_valid/addr/data     oldest entry; addr/data forced to 0 when empty
//   i_srch_addr                address to look up among valid entries
//   o_srch_hit/o_srch_data     youngest matching entry (data 0 when no hit)
//   o_count                    entries held, 0..DEPTH
module wb_fifo
    import pic_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_head_valid,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    input  logic [ADDR_W-1:0] i_srch_addr,
    output logic              o_srch_hit,
    output logic [DATA_W-1:0] o_srch_data,
    output logic [CNT_W-1:0]  o_count
);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: every read is qualified by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= i_push_addr;
            r_mem_data[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_valid = !w_empty;
    assign o_head_addr  = w_empty ? '0 : r_mem_addr[r_rd_ptr];
    assign o_head_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign o_count      = r_count;

    // Walk oldest to youngest; the last match written wins, giving the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        o_srch_hit  = 1'b0;
        o_srch_data = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_mem_addr[idx] == i_srch_addr)) begin
                o_srch_hit  = 1'b1;
                o_srch_data = r_mem_data[idx];
            end
        end
    end

endmodule

// File: rtl/reg_write_queue.sv
// Write-back controller for the PIC16C5x register file.
// Decodes one write request per cycle into a queued GPR write, a STATUS update
// and/or an FSR load. GPR writes drain through a stallable write port; queued
// writes are searchable so execute can read values that have not landed yet.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   bus (slave)                    request channel and GPR write channel
//   i_flush                        discard all queued GPR writes
//   o_status_wr_en/o_status_wr_data  one-cycle STATUS write, registered
//   o_fsr_wr_en/o_fsr_wr_data        one-cycle FSR write, registered
//   i_rd_addr, o_fwd_hit, o_fwd_data forward lookup of the youngest queued write
//   o_pending                      queued entry count
module reg_write_queue
    import pic_wb_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned STATUS_W = DEF_STATUS_W,
    parameter int unsigned ZBIT     = BIT_Z
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    reg_write_queue_if.slave           bus,
    input  logic                       i_flush,
    output logic                       o_status_wr_en,
    output logic [DATA_W-1:0]          o_status_wr_data,
    output logic                       o_fsr_wr_en,
    output logic [DATA_W-1:0]          o_fsr_wr_data,
    input  logic [ADDR_W-1:0]          i_rd_addr,
    output logic                       o_fwd_hit,
    output logic [DATA_W-1:0]          o_fwd_data,
    output logic [$clog2(DEPTH):0]     o_pending
);

    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_status_upd;
    logic [DATA_W-1:0] w_status_next;
    logic              w_fsr_ld;

    logic              r_status_wr_en;
    logic [DATA_W-1:0] r_status_wr_data;
    logic              r_fsr_wr_en;
    logic [DATA_W-1:0] r_fsr_wr_data;

    assign w_pop         = bus.wr_en && bus.wr_ready;
    assign bus.req_ready = !w_full || w_pop;
    assign w_accept      = bus.req_valid && bus.req_ready && (bus.req_op != OP_NOP);
    assign w_push        = w_accept && is_gpr_push(bus.req_op, bus.req_dest);
    assign w_status_upd  = w_accept && is_status_upd(bus.req_op);
    assign w_fsr_ld      = w_accept && (bus.req_op == OP_FSR_LD);

    always_comb begin
        w_push_data = bus.alu_result;
        if (bus.req_op == OP_CLRF) begin
            w_push_data = '0;
        end else if (bus.req_op == OP_MOVWF) begin
            w_push_data = bus.w_in;
        end
    end

    // Clears only raise Z; ALU-type ops overwrite the whole flag field.
    always_comb begin
        w_status_next = bus.status_in;
        if ((bus.req_op == OP_CLRF) || (bus.req_op == OP_CLRW)) begin
            w_status_next[ZBIT] = 1'b1;
        end else begin
            w_status_next[STATUS_W-1:0] = bus.alu_status;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_status_wr_en   <= 1'b0;
            r_status_wr_data <= '0;
            r_fsr_wr_en      <= 1'b0;
            r_fsr_wr_data    <= '0;
        end else begin
            r_status_wr_en <= w_status_upd;
            r_fsr_wr_en    <= w_fsr_ld;
            if (w_status_upd) r_status_wr_data <= w_status_next;
            if (w_fsr_ld)     r_fsr_wr_data    <= bus.alu_result;
        end
    end

    assign o_status_wr_en   = r_status_wr_en;
    assign o_status_wr_data = r_status_wr_data;
    assign o_fsr_wr_en      = r_fsr_wr_en;
    assign o_fsr_wr_data    = r_fsr_wr_data;

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_push       (w_push),
        .i_push_addr  (bus.req_addr),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_full       (w_full),
        .o_head_valid (bus.wr_en),
        .o_head_addr  (bus.wr_addr),
        .o_head_data  (bus.wr_data),
        .i_srch_addr  (i_rd_addr),
        .o_srch_hit   (o_fwd_hit),
        .o_srch_data  (o_fwd_data),
        .o_count      (o_pending)
    );

endmodule

// File: tb/tb_reg_write_queue.sv
module tb_reg_write_queue;
    import pic_wb_pkg::*;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned STATUS_W = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              status_wr_en;
    logic [DATA_W-1:0] status_wr_data;
    logic              fsr_wr_en;
    logic [DATA_W-1:0] fsr_wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [2:0]        pending;

    int n_total;
    int n_pass;

    reg_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STATUS_W(STATUS_W)) bus ();

    reg_write_queue #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .STATUS_W (STATUS_W),
        .ZBIT     (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .bus              (bus),
        .i_flush          (flush),
        .o_status_wr_en   (status_wr_en),
        .o_status_wr_data (status_wr_data),
        .o_fsr_wr_en      (fsr_wr_en),
        .o_fsr_wr_data    (fsr_wr_data),
        .i_rd_addr        (rd_addr),
        .o_fwd_hit        (fwd_hit),
        .o_fwd_data       (fwd_data),
        .o_pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic d, input logic [4:0] a,
                       input logic [7:0] w, input logic [7:0] r, input logic [2:0] st,
                       input logic [7:0] sin);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_dest   = d;
        bus.req_addr   = a;
        bus.w_in       = w;
        bus.alu_result = r;
        bus.alu_status = st;
        bus.status_in  = sin;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        rd_addr = '0;
        bus.req_valid = 1'b0;
        bus.req_op = OP_NOP;
        bus.req_dest = 1'b0;
        bus.req_addr = '0;
        bus.w_in = '0;
        bus.alu_result = '0;
        bus.alu_status = '0;
        bus.status_in = '0;
        bus.wr_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_wr_en", 16'(bus.wr_en), 16'h0);
        check("rst_wr_addr", 16'(bus.wr_addr), 16'h0);
        check("rst_wr_data", 16'(bus.wr_data), 16'h0);
        check("rst_status_en", 16'(status_wr_en), 16'h0);
        check("rst_status_data", 16'(status_wr_data), 16'h0);
        check("rst_fsr_en", 16'(fsr_wr_en), 16'h0);
        check("rst_fsr_data", 16'(fsr_wr_data), 16'h0);
        check("rst_fwd_hit", 16'(fwd_hit), 16'h0);
        check("rst_fwd_data", 16'(fwd_data), 16'h0);
        check("rst_pending", 16'(pending), 16'h0);
        check("rst_req_ready", 16'(bus.req_ready), 16'h1);

        // MOVWF 0x0A <- 0x5C
        req(OP_MOVWF, 1'b0, 5'h0A, 8'h5C, 8'hEE, 3'b111, 8'h00);
        rd_addr = 5'h0A;
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("movwf_wr_en", 16'(bus.wr_en), 16'h1);
        check("movwf_wr_addr", 16'(bus.wr_addr), 16'h0A);
        check("movwf_wr_data", 16'(bus.wr_data), 16'h5C);
        check("movwf_status_en", 16'(status_wr_en), 16'h0);
        check("movwf_pending", 16'(pending), 16'h1);
        check("movwf_fwd_hit", 16'(fwd_hit), 16'h1);
        check("movwf_fwd_data", 16'(fwd_data), 16'h5C);
        tick();
        check("movwf_drained", 16'(pending), 16'h0);
        check("movwf_wr_en_off", 16'(bus.wr_en), 16'h0);

        // CLRF 0x10 with STATUS 0x18 -> Z set
        req(OP_CLRF, 1'b0, 5'h10, 8'h77, 8'h66, 3'b000, 8'h18);
        tick();
        bus.req_valid = 1'b0;
        check("clrf_wr_addr", 16'(bus.wr_addr), 16'h10);
        check("clrf_wr_data", 16'(bus.wr_data), 16'h00);
        check("clrf_status_en", 16'(status_wr_en), 16'h1);
        check("clrf_status_data", 16'(status_wr_data), 16'h1C);
        tick();
        check("clrf_status_pulse", 16'(status_wr_en), 16'h0);
        check("clrf_pending", 16'(pending), 16'h0);

        // CLRW: status only, no push
        req(OP_CLRW, 1'b0, 5'h11, 8'h00, 8'h00, 3'b000, 8'h03);
        tick();
        bus.req_valid = 1'b0;
        check("clrw_status_data", 16'(status_wr_data), 16'h07);
        check("clrw_no_push", 16'(pending), 16'h0);

        // Fill with write port stalled: 4 fit, 5th waits
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(OP_ALU_F, 1'b1, 5'(i + 1), 8'h00, 8'(8'h41 + i), 3'b010, 8'h00);
            #1;
            check("fill_req_ready", 16'(bus.req_ready), (i < 4) ? 16'h1 : 16'h0);
            tick();
        end
        check("fill_pending", 16'(pending), 16'h4);
        check("fill_status_en", 16'(status_wr_en), 16'h0);
        check("fill_head_addr", 16'(bus.wr_addr), 16'h01);
        check("fill_head_data", 16'(bus.wr_data), 16'h41);
        // Release: 5th request goes in alongside the pop
        bus.wr_ready = 1'b1;
        #1;
        check("full_pop_ready", 16'(bus.req_ready), 16'h1);
        tick();
        bus.req_valid = 1'b0;
        check("full_pop_pending", 16'(pending), 16'h4);
        for (int i = 2; i <= 5; i++) begin
            check("drain_addr", 16'(bus.wr_addr), 16'(i));
            check("drain_data", 16'(bus.wr_data), 16'(8'h40 + i));
            tick();
        end
        check("drain_empty", 16'(pending), 16'h0);

        // Forwarding: youngest of two writes to 0x0C
        bus.wr_ready = 1'b0;
        req(OP_MOVWF, 1'b0, 5'h0C, 8'h11, 8'h00, 3'b000, 8'h00);
        tick();
        req(OP_MOVWF, 1'b0, 5'h0C, 8'h22, 8'h00, 3'b000, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        rd_addr = 5'h0C;
        #1;
        check("fwd_hit", 16'(fwd_hit), 16'h1);
        check("fwd_youngest", 16'(fwd_data), 16'h22);
        rd_addr = 5'h0D;
        #1;
        check("fwd_miss_hit", 16'(fwd_hit), 16'h0);
        check("fwd_miss_data", 16'(fwd_data), 16'h00);

        // Flush 3 entries with a concurrent ALU_F push
        req(OP_MOVWF, 1'b0, 5'h0E, 8'h33, 8'h00, 3'b000, 8'h00);
        tick();
        check("preflush_pending", 16'(pending), 16'h3);
        req(OP_ALU_F, 1'b1, 5'h0F, 8'h00, 8'h77, 3'b101, 8'hF0);
        flush = 1'b1;
        rd_addr = 5'h0F;
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_pending", 16'(pending), 16'h0);
        check("flush_wr_en", 16'(bus.wr_en), 16'h0);
        check("flush_fwd_hit", 16'(fwd_hit), 16'h0);
        check("flush_status_en", 16'(status_wr_en), 16'h1);
        check("flush_status_data", 16'(status_wr_data), 16'hF5);

        // FSR_LD: FSR strobe only
        req(OP_FSR_LD, 1'b1, 5'h01, 8'h00, 8'h9A, 3'b111, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        check("fsr_en", 16'(fsr_wr_en), 16'h1);
        check("fsr_data", 16'(fsr_wr_data), 16'h9A);
        check("fsr_no_status", 16'(status_wr_en), 16'h0);
        check("fsr_no_push", 16'(pending), 16'h0);
        tick();
        check("fsr_pulse", 16'(fsr_wr_en), 16'h0);

        // Reset with 2 queued and FSR_LD in flight
        req(OP_MOVWF, 1'b0, 5'h02, 8'hA1, 8'h00, 3'b000, 8'h00);
        tick();
        req(OP_MOVWF, 1'b0, 5'h03, 8'hA2, 8'h00, 3'b000, 8'h00);
        tick();
        check("prerst_pending", 16'(pending), 16'h2);
        req(OP_FSR_LD, 1'b0, 5'h00, 8'h00, 8'h3C, 3'b000, 8'h00);
        rst_n = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        check("midrst_fsr_en", 16'(fsr_wr_en), 16'h0);
        check("midrst_status_en", 16'(status_wr_en), 16'h0);
        check("midrst_pending", 16'(pending), 16'h0);
        check("midrst_wr_en", 16'(bus.wr_en), 16'h0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
